// File: rtl/nasti_dma_pkg.sv
// -----------------------------------------------------------------------------
// nasti_dma_pkg
// Shared definitions for the NASTI copy engine: controller state encoding,
// the 4 KiB page size that no burst may cross, and the NASTI burst/response
// encodings, plus a small helper that classifies a response as an error.
// -----------------------------------------------------------------------------
package nasti_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        RESP = 3'd4
    } state_e;

    localparam int unsigned PAGE_BYTES = 4096;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR are the only responses with bit 1 set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/nasti_dma_mover_if.sv
// -----------------------------------------------------------------------------
// nasti_channel
// One full NASTI port (AR, AW, W, B, R). The master modport is the side that
// issues addresses and write data; the slave modport is the memory side.
// -----------------------------------------------------------------------------
interface nasti_channel #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    import nasti_dma_pkg::*;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
        input  ar_ready,
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
        output ar_ready,
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/nasti_dma_burst_calc.sv
// -----------------------------------------------------------------------------
// nasti_dma_burst_calc
// Combinational burst sizer: beats = min(remaining, MAX_BURST, beats left in
// the source 4 KiB page, beats left in the destination 4 KiB page).
// Ports:
//   src_addr, dest_addr : current beat-aligned byte addresses
//   remaining           : beats still to copy
//   beats               : beats for the next burst (1..MAX_BURST when remaining != 0)
// -----------------------------------------------------------------------------
module nasti_dma_burst_calc
    import nasti_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 256
) (
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic [ADDR_WIDTH-1:0] remaining,
    output logic [8:0]            beats
);

    localparam int          SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [12:0] PAGE  = 13'(PAGE_BYTES);
    localparam logic [12:0] CAP   = 13'(MAX_BURST);

    // Page offset 0 yields a full page (4096 >> SHIFT), hence the 13-bit math.
    function automatic logic [12:0] page_left(input logic [11:0] offset);
        return (PAGE - {1'b0, offset}) >> SHIFT;
    endfunction

    function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [12:0] limit_s;
    logic        unused_s;

    // Page and burst-length caps, then the remaining-beats cap in full width.
    always_comb begin
        limit_s = min13(CAP, min13(page_left(src_addr[11:0]), page_left(dest_addr[11:0])));
        if (remaining < ADDR_WIDTH'(limit_s)) begin
            beats = remaining[8:0];
        end else begin
            beats = limit_s[8:0];
        end
    end

    assign unused_s = ^{src_addr[ADDR_WIDTH-1:12], dest_addr[ADDR_WIDTH-1:12]};

endmodule

// File: rtl/nasti_dma_mover.sv
// -----------------------------------------------------------------------------
// nasti_dma_mover
// Copies `length` bytes from the src NASTI slave to the dest NASTI slave as a
// sequence of single outstanding bursts. R beats flow straight into W.
// Ports:
//   aclk, areset        : clock, asynchronous active-high reset
//   src  (master)       : read side, AR/R only
//   dest (master)       : write side, AW/W/B only
//   src_addr, dest_addr : start byte addresses (beat aligned)
//   length              : byte count (multiple of the beat size)
//   start               : one-cycle request, honoured only when idle
//   busy, done, error   : status; error is sticky until the next start
// -----------------------------------------------------------------------------
module nasti_dma_mover
    import nasti_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 256,
    parameter int ID         = 0,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    nasti_channel.master          src,
    nasti_channel.master          dest,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int                  BEAT       = DATA_WIDTH / 8;
    localparam int                  SHIFT      = $clog2(BEAT);
    localparam logic [ADDR_WIDTH-1:0] ZERO       = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEAT - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d;
    logic [8:0]            beats_q, beats_d;
    logic                  ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d, b_ready_q, b_ready_d;
    logic                  last_seen_q, last_seen_d, b_seen_q, b_seen_d;
    logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [8:0]            calc_beats_s;
    logic                  r_fire_s, last_fire_s, b_take_s;
    logic [ADDR_WIDTH-1:0] step_bytes_s, rem_next_s;
    logic                  unused_s;

    nasti_dma_burst_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .src_addr   (src_q),
        .dest_addr  (dst_q),
        .remaining  (rem_q),
        .beats      (calc_beats_s)
    );

    // Only the first B of a burst is taken; b_ready stays high until RESP ends.
    assign r_fire_s     = src.r_valid & dest.w_ready;
    assign last_fire_s  = r_fire_s & src.r_last;
    assign b_take_s     = dest.b_valid & b_ready_q & ~b_seen_q;
    assign step_bytes_s = ADDR_WIDTH'(beats_q) << SHIFT;
    assign rem_next_s   = rem_q - ADDR_WIDTH'(beats_q);

    // Read side: AR from the latches, R consumed exactly when W is accepted.
    assign src.ar_id    = ID_WIDTH'(ID);
    assign src.ar_addr  = src_q;
    assign src.ar_len   = 8'(beats_q - 9'd1);
    assign src.ar_size  = 3'(SHIFT);
    assign src.ar_burst = BURST_INCR;
    assign src.ar_lock  = 1'b0;
    assign src.ar_cache = 4'd0;
    assign src.ar_prot  = 3'd0;
    assign src.ar_valid = ar_valid_q;
    assign src.r_ready  = dest.w_ready;
    assign src.aw_id    = {ID_WIDTH{1'b0}};
    assign src.aw_addr  = ZERO;
    assign src.aw_len   = 8'd0;
    assign src.aw_size  = 3'd0;
    assign src.aw_burst = 2'd0;
    assign src.aw_lock  = 1'b0;
    assign src.aw_cache = 4'd0;
    assign src.aw_prot  = 3'd0;
    assign src.aw_valid = 1'b0;
    assign src.w_data   = {DATA_WIDTH{1'b0}};
    assign src.w_strb   = {BEAT{1'b0}};
    assign src.w_last   = 1'b0;
    assign src.w_valid  = 1'b0;
    assign src.b_ready  = 1'b0;

    // Write side: AW mirrors AR, W is the R stream passed through.
    assign dest.aw_id    = ID_WIDTH'(ID);
    assign dest.aw_addr  = dst_q;
    assign dest.aw_len   = 8'(beats_q - 9'd1);
    assign dest.aw_size  = 3'(SHIFT);
    assign dest.aw_burst = BURST_INCR;
    assign dest.aw_lock  = 1'b0;
    assign dest.aw_cache = 4'd0;
    assign dest.aw_prot  = 3'd0;
    assign dest.aw_valid = aw_valid_q;
    assign dest.w_data   = src.r_data;
    assign dest.w_strb   = {BEAT{1'b1}};
    assign dest.w_last   = src.r_last;
    assign dest.w_valid  = src.r_valid;
    assign dest.b_ready  = b_ready_q;
    assign dest.ar_id    = {ID_WIDTH{1'b0}};
    assign dest.ar_addr  = ZERO;
    assign dest.ar_len   = 8'd0;
    assign dest.ar_size  = 3'd0;
    assign dest.ar_burst = 2'd0;
    assign dest.ar_lock  = 1'b0;
    assign dest.ar_cache = 4'd0;
    assign dest.ar_prot  = 3'd0;
    assign dest.ar_valid = 1'b0;
    assign dest.r_ready  = 1'b0;

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    assign unused_s = ^{src.aw_ready, src.w_ready, src.b_id, src.b_resp, src.b_valid, src.r_id,
                        dest.ar_ready, dest.r_id, dest.r_data, dest.r_resp, dest.r_last,
                        dest.r_valid, dest.b_id};

    // Controller next-state and output decode.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        beats_d     = beats_q;
        ar_valid_d  = ar_valid_q;
        aw_valid_d  = aw_valid_q;
        b_ready_d   = b_ready_q;
        // The last beat can already pass during ADDR when AR wins over AW.
        last_seen_d = last_seen_q | last_fire_s;
        b_seen_d    = b_seen_q | b_take_s;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q | (r_fire_s & resp_is_err(src.r_resp))
                              | (b_take_s & resp_is_err(dest.b_resp));
        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (length == ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        src_d   = src_addr & ALIGN_MASK;
                        dst_d   = dest_addr & ALIGN_MASK;
                        rem_d   = length >> SHIFT;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                beats_d     = calc_beats_s;
                ar_valid_d  = 1'b1;
                aw_valid_d  = 1'b1;
                last_seen_d = 1'b0;
                b_seen_d    = 1'b0;
                state_d     = ADDR;
            end
            ADDR: begin
                ar_valid_d = ar_valid_q & ~src.ar_ready;
                aw_valid_d = aw_valid_q & ~dest.aw_ready;
                if (!ar_valid_d && !aw_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (last_seen_q || last_fire_s) begin
                    state_d = RESP;
                end else begin
                    state_d = DATA;
                end
            end
            RESP: begin
                if (b_seen_q || b_take_s) begin
                    b_ready_d = 1'b0;
                    src_d     = src_q + step_bytes_s;
                    dst_d     = dst_q + step_bytes_s;
                    rem_d     = rem_next_s;
                    if (rem_next_s == ZERO) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                ar_valid_d = 1'b0;
                aw_valid_d = 1'b0;
                b_ready_d  = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            src_q       <= ZERO;
            dst_q       <= ZERO;
            rem_q       <= ZERO;
            beats_q     <= 9'd0;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            last_seen_q <= 1'b0;
            b_seen_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            ar_valid_q  <= ar_valid_d;
            aw_valid_q  <= aw_valid_d;
            b_ready_q   <= b_ready_d;
            last_seen_q <= last_seen_d;
            b_seen_q    <= b_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_nasti_dma_mover.sv
// -----------------------------------------------------------------------------
// tb_nasti_dma_mover
// Directed bench for nasti_dma_mover (ADDR_WIDTH=32, DATA_WIDTH=64,
// MAX_BURST=256) with simple source/destination slave models.
// -----------------------------------------------------------------------------
module tb_nasti_dma_mover;
    import nasti_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_addr, dest_addr, length;
    logic        start;
    logic        busy, done, error;

    int checks = 0;
    int failures = 0;

    nasti_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) src_if ();
    nasti_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) dest_if ();

    nasti_dma_mover #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(256), .ID(0), .ID_WIDTH(4)
    ) dut (
        .aclk(clk), .areset(rst), .src(src_if), .dest(dest_if),
        .src_addr(src_addr), .dest_addr(dest_addr), .length(length),
        .start(start), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // ---------------- source slave: one read burst at a time ----------------
    logic        rd_active = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic [8:0]  rd_left = 9'd0;
    int          ar_cnt = 0;
    logic [31:0] ar_addr_log [64];
    logic [7:0]  ar_len_log  [64];

    assign src_if.ar_ready = ~rd_active;
    assign src_if.r_valid  = rd_active;
    assign src_if.r_data   = {~rd_addr, rd_addr};
    assign src_if.r_last   = (rd_left == 9'd1);
    assign src_if.r_resp   = RESP_OKAY;
    assign src_if.r_id     = 4'd0;
    assign src_if.aw_ready = 1'b0;
    assign src_if.w_ready  = 1'b0;
    assign src_if.b_valid  = 1'b0;
    assign src_if.b_resp   = 2'b00;
    assign src_if.b_id     = 4'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_active <= 1'b0;
            rd_left   <= 9'd0;
        end else if (src_if.ar_valid && src_if.ar_ready) begin
            rd_active              <= 1'b1;
            rd_addr                <= src_if.ar_addr;
            rd_left                <= 9'(src_if.ar_len) + 9'd1;
            ar_addr_log[ar_cnt%64] <= src_if.ar_addr;
            ar_len_log[ar_cnt%64]  <= src_if.ar_len;
            ar_cnt                 <= ar_cnt + 1;
        end else if (rd_active && src_if.r_ready) begin
            rd_addr <= rd_addr + 32'd8;
            rd_left <= rd_left - 9'd1;
            if (rd_left == 9'd1) rd_active <= 1'b0;
        end
    end

    // ---------------- destination slave + W/handshake monitor ----------------
    int          aw_delay = 0;
    int          err_burst = -1;
    int          aw_wait = 0, aw_cnt = 0, wl_cnt = 0, b_cnt = 0;
    int          w_cnt = 0, w_bad = 0, ar_vcyc = 0, aw_vcyc = 0, done_cnt = 0;
    logic [31:0] exp_src_base = 32'd0;
    int          w_base = 0;
    logic [31:0] aw_addr_log [64];
    logic [7:0]  aw_len_log  [64];
    logic        b_valid_r = 1'b0;
    logic [1:0]  b_resp_r = 2'b00;
    logic [31:0] exp_a;

    assign exp_a            = exp_src_base + 32'((w_cnt - w_base) * 8);
    assign dest_if.aw_ready = (aw_wait >= aw_delay);
    assign dest_if.w_ready  = 1'b1;
    assign dest_if.b_valid  = b_valid_r;
    assign dest_if.b_resp   = b_resp_r;
    assign dest_if.b_id     = 4'd0;
    assign dest_if.ar_ready = 1'b0;
    assign dest_if.r_valid  = 1'b0;
    assign dest_if.r_data   = 64'd0;
    assign dest_if.r_last   = 1'b0;
    assign dest_if.r_resp   = 2'b00;
    assign dest_if.r_id     = 4'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait   <= 0;
            b_valid_r <= 1'b0;
        end else begin
            if (dest_if.aw_valid && dest_if.aw_ready) begin
                aw_wait                <= 0;
                aw_addr_log[aw_cnt%64] <= dest_if.aw_addr;
                aw_len_log[aw_cnt%64]  <= dest_if.aw_len;
                aw_cnt                 <= aw_cnt + 1;
            end else if (dest_if.aw_valid) begin
                aw_wait <= aw_wait + 1;
            end
            if (dest_if.w_valid && dest_if.w_ready) begin
                w_cnt <= w_cnt + 1;
                if (dest_if.w_data !== {~exp_a, exp_a} || dest_if.w_strb !== 8'hFF) w_bad <= w_bad + 1;
                if (dest_if.w_last) wl_cnt <= wl_cnt + 1;
            end
            if (b_valid_r && dest_if.b_ready) begin
                b_valid_r <= 1'b0;
                b_cnt     <= b_cnt + 1;
            end else if (!b_valid_r && aw_cnt > b_cnt && wl_cnt > b_cnt) begin
                b_valid_r <= 1'b1;
                b_resp_r  <= (b_cnt == err_burst) ? RESP_SLVERR : RESP_OKAY;
            end
            if (src_if.ar_valid) ar_vcyc <= ar_vcyc + 1;
            if (dest_if.aw_valid) aw_vcyc <= aw_vcyc + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int ar0, aw0, wbad0, done0, arv0, awv0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is held across exactly one posedge.
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        ar0 = ar_cnt; aw0 = aw_cnt; w_base = w_cnt; wbad0 = w_bad;
        done0 = done_cnt; arv0 = ar_vcyc; awv0 = aw_vcyc; exp_src_base = s;
        src_addr = s; dest_addr = d; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, 64'(n < 3000), 64'd1);
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; src_addr = 32'd0; dest_addr = 32'd0; length = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_ar_valid", 64'(src_if.ar_valid), 64'd0);
        chk("rst_aw_valid", 64'(dest_if.aw_valid), 64'd0);
        chk("rst_b_ready", 64'(dest_if.b_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single 256-beat burst
        start_xfer(32'h1000, 32'h8000, 32'h800);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1");
        chk("t1_ar_cnt", 64'(ar_cnt - ar0), 64'd1);
        chk("t1_ar_addr", 64'(ar_addr_log[ar0%64]), 64'h1000);
        chk("t1_ar_len", 64'(ar_len_log[ar0%64]), 64'd255);
        chk("t1_aw_addr", 64'(aw_addr_log[aw0%64]), 64'h8000);
        chk("t1_aw_len", 64'(aw_len_log[aw0%64]), 64'd255);
        chk("t1_w_beats", 64'(w_cnt - w_base), 64'd256);
        chk("t1_w_data", 64'(w_bad - wbad0), 64'd0);
        chk("t1_done_once", 64'(done_cnt - done0), 64'd1);
        chk("t1_error", 64'(error), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // 2: 514 beats from 0x0 -> 256, 256, 2
        start_xfer(32'h0, 32'h10000, 32'h1010);
        wait_done("t2");
        chk("t2_ar_cnt", 64'(ar_cnt - ar0), 64'd3);
        chk("t2_ar_addr1", 64'(ar_addr_log[(ar0+1)%64]), 64'h800);
        chk("t2_ar_addr2", 64'(ar_addr_log[(ar0+2)%64]), 64'h1000);
        chk("t2_ar_len0", 64'(ar_len_log[ar0%64]), 64'd255);
        chk("t2_ar_len1", 64'(ar_len_log[(ar0+1)%64]), 64'd255);
        chk("t2_ar_len2", 64'(ar_len_log[(ar0+2)%64]), 64'd1);
        chk("t2_aw_addr2", 64'(aw_addr_log[(aw0+2)%64]), 64'h11000);
        chk("t2_aw_len2", 64'(aw_len_log[(aw0+2)%64]), 64'd1);
        chk("t2_w_beats", 64'(w_cnt - w_base), 64'd514);
        chk("t2_w_data", 64'(w_bad - wbad0), 64'd0);

        // 3: source page split 2 + 6 beats
        start_xfer(32'h0FF0, 32'h2000, 32'h40);
        wait_done("t3");
        chk("t3_ar_cnt", 64'(ar_cnt - ar0), 64'd2);
        chk("t3_ar_len0", 64'(ar_len_log[ar0%64]), 64'd1);
        chk("t3_ar_addr1", 64'(ar_addr_log[(ar0+1)%64]), 64'h1000);
        chk("t3_ar_len1", 64'(ar_len_log[(ar0+1)%64]), 64'd5);
        chk("t3_aw_addr1", 64'(aw_addr_log[(aw0+1)%64]), 64'h2010);
        chk("t3_w_beats", 64'(w_cnt - w_base), 64'd8);
        chk("t3_w_data", 64'(w_bad - wbad0), 64'd0);

        // 4: AW stalled 20 cycles, AR accepted at once
        aw_delay = 20;
        start_xfer(32'h0, 32'h3000, 32'h100);
        wait_done("t4");
        aw_delay = 0;
        chk("t4_ar_valid_cycles", 64'(ar_vcyc - arv0), 64'd1);
        chk("t4_aw_valid_cycles", 64'(aw_vcyc - awv0), 64'd21);
        chk("t4_aw_len", 64'(aw_len_log[aw0%64]), 64'd31);
        chk("t4_w_beats", 64'(w_cnt - w_base), 64'd32);
        chk("t4_w_data", 64'(w_bad - wbad0), 64'd0);
        chk("t4_done_once", 64'(done_cnt - done0), 64'd1);

        // 5: SLVERR on the 2nd of 3 bursts; the 3rd is still issued
        err_burst = b_cnt + 1;
        start_xfer(32'h0, 32'h4000, 32'h1010);
        wait_done("t5");
        err_burst = -1;
        chk("t5_ar_cnt", 64'(ar_cnt - ar0), 64'd3);
        chk("t5_aw_cnt", 64'(aw_cnt - aw0), 64'd3);
        chk("t5_error", 64'(error), 64'd1);
        start_xfer(32'h0, 32'h6000, 32'h40);
        chk("t5_error_cleared", 64'(error), 64'd0);
        wait_done("t5b");
        chk("t5b_error", 64'(error), 64'd0);

        // 6a: zero length
        start_xfer(32'h100, 32'h200, 32'h0);
        chk("t6_done_pulse", 64'(done), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t6_done_low", 64'(done), 64'd0);
        chk("t6_no_ar", 64'(ar_cnt - ar0), 64'd0);
        chk("t6_no_aw", 64'(aw_cnt - aw0), 64'd0);

        // 6b: reset in the middle of DATA
        start_xfer(32'h0, 32'h5000, 32'h800);
        begin
            int n;
            n = 0;
            while ((w_cnt - w_base) < 10 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            chk("t6_data_started", 64'(n < 1000), 64'd1);
        end
        chk("t6_busy_mid", 64'(busy), 64'd1);
        chk("t6_b_ready_mid", 64'(dest_if.b_ready), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_error", 64'(error), 64'd0);
        chk("t6_rst_ar_valid", 64'(src_if.ar_valid), 64'd0);
        chk("t6_rst_aw_valid", 64'(dest_if.aw_valid), 64'd0);
        chk("t6_rst_b_ready", 64'(dest_if.b_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_after_rst", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
